// File: rtl/uart_cfg_master.sv
// Purpose: AXI4-lite master that brings the UART up after reset or on start: FIFO reset, divisor, enables, status poll.
// Latency: 2 cycles per write or read at the minimum, 8 cycles from sequence start to done.
// Backpressure: each valid is held, with its address and data, until its own handshake; every phase is bounded by a timeout.
//
// Ports:
//   clk, rst                  clock and asynchronous active-high reset
//   start                     single-cycle request, honoured only in IDLE, DONE or ERROR
//   busy, done, error         sequence status; done and error are held until the next start
//   err_code                  0 none, 1 write response error, 2 read response error, 3 timeout or poll limit
//   m_axi_aw*/w*/b*/ar*/r*    AXI4-lite master port toward the UART register slave
module uart_cfg_master #(
    parameter int                        AXI_ADDR_WIDTH = 32,
    parameter int                        AXI_DATA_WIDTH = 32,
    parameter logic [AXI_ADDR_WIDTH-1:0] AXI_BASE_ADDR  = '0,
    parameter logic [AXI_ADDR_WIDTH-1:0] CTRL_OFFSET    = 'h00,
    parameter logic [AXI_ADDR_WIDTH-1:0] DIV_OFFSET     = 'h04,
    parameter logic [AXI_ADDR_WIDTH-1:0] STATUS_OFFSET  = 'h08,
    parameter logic [15:0]               BAUD_DIV       = 16'd868,
    parameter bit                        RX_ENABLE      = 1'b1,
    parameter bit                        TX_ENABLE      = 1'b1,
    parameter int                        POLL_LIMIT     = 16,
    parameter int                        TIMEOUT_CYCLES = 1024,
    parameter bit                        AUTO_START     = 1'b1
) (
    input  logic                        clk,
    input  logic                        rst,
    input  logic                        start,
    output logic                        busy,
    output logic                        done,
    output logic                        error,
    output logic [1:0]                  err_code,
    output logic [AXI_ADDR_WIDTH-1:0]   m_axi_awaddr,
    output logic [2:0]                  m_axi_awprot,
    output logic                        m_axi_awvalid,
    input  logic                        m_axi_awready,
    output logic [AXI_DATA_WIDTH-1:0]   m_axi_wdata,
    output logic [AXI_DATA_WIDTH/8-1:0] m_axi_wstrb,
    output logic                        m_axi_wvalid,
    input  logic                        m_axi_wready,
    input  logic [1:0]                  m_axi_bresp,
    input  logic                        m_axi_bvalid,
    output logic                        m_axi_bready,
    output logic [AXI_ADDR_WIDTH-1:0]   m_axi_araddr,
    output logic [2:0]                  m_axi_arprot,
    output logic                        m_axi_arvalid,
    input  logic                        m_axi_arready,
    input  logic [AXI_DATA_WIDTH-1:0]   m_axi_rdata,
    input  logic [1:0]                  m_axi_rresp,
    input  logic                        m_axi_rvalid,
    output logic                        m_axi_rready
);

    typedef enum logic [2:0] {
        IDLE, WR_REQ, WR_RESP, RD_REQ, RD_RESP, DONE, ERROR
    } state_t;

    localparam int TW = $clog2(TIMEOUT_CYCLES + 1);
    localparam int PW = $clog2(POLL_LIMIT + 1);
    localparam int SW = AXI_DATA_WIDTH / 8;

    // Base plus offset wraps within the address width.
    localparam logic [AXI_ADDR_WIDTH-1:0] CTRL_ADDR   = AXI_BASE_ADDR + CTRL_OFFSET;
    localparam logic [AXI_ADDR_WIDTH-1:0] DIV_ADDR    = AXI_BASE_ADDR + DIV_OFFSET;
    localparam logic [AXI_ADDR_WIDTH-1:0] STATUS_ADDR = AXI_BASE_ADDR + STATUS_OFFSET;

    function automatic logic [AXI_ADDR_WIDTH-1:0] step_addr(input logic [1:0] s);
        return (s == 2'd1) ? DIV_ADDR : CTRL_ADDR;
    endfunction

    function automatic logic [AXI_DATA_WIDTH-1:0] step_data(input logic [1:0] s);
        logic [AXI_DATA_WIDTH-1:0] d;
        case (s)
            2'd0:    d = AXI_DATA_WIDTH'(32'h3);
            2'd1:    d = AXI_DATA_WIDTH'({16'h0, BAUD_DIV});
            default: d = AXI_DATA_WIDTH'({28'h0, TX_ENABLE, RX_ENABLE, 2'b00});
        endcase
        return d;
    endfunction

    function automatic logic is_active(input state_t s);
        return (s == WR_REQ) || (s == WR_RESP) || (s == RD_REQ) || (s == RD_RESP);
    endfunction

    state_t                      state_q, state_d;
    logic [1:0]                  step_q, step_d;
    logic [PW-1:0]               poll_q, poll_d;
    logic [TW-1:0]               timer_q, timer_d;
    logic                        armed_q, armed_d;
    logic                        auto_q, auto_d;
    logic                        busy_q, busy_d;
    logic                        done_q, done_d;
    logic                        error_q, error_d;
    logic [1:0]                  err_code_q, err_code_d;
    logic                        awvalid_q, awvalid_d;
    logic [AXI_ADDR_WIDTH-1:0]   awaddr_q, awaddr_d;
    logic                        wvalid_q, wvalid_d;
    logic [AXI_DATA_WIDTH-1:0]   wdata_q, wdata_d;
    logic [SW-1:0]               wstrb_q, wstrb_d;
    logic                        bready_q, bready_d;
    logic                        arvalid_q, arvalid_d;
    logic [AXI_ADDR_WIDTH-1:0]   araddr_q, araddr_d;
    logic                        rready_q, rready_d;

    // Only the error bit of each response and the ready bit of STATUS matter.
    logic unused_rsp;
    assign unused_rsp = ^{m_axi_bresp[0], m_axi_rresp[0], m_axi_rdata[AXI_DATA_WIDTH-1:1]};

    always_comb begin
        state_d    = state_q;
        step_d     = step_q;
        poll_d     = poll_q;
        timer_d    = '0;
        armed_d    = 1'b0;
        // auto_q is high for exactly the first cycle after reset release.
        auto_d     = armed_q & AUTO_START;
        busy_d     = busy_q;
        done_d     = done_q;
        error_d    = error_q;
        err_code_d = err_code_q;
        awvalid_d  = awvalid_q;
        awaddr_d   = awaddr_q;
        wvalid_d   = wvalid_q;
        wdata_d    = wdata_q;
        wstrb_d    = wstrb_q;
        bready_d   = bready_q;
        arvalid_d  = arvalid_q;
        araddr_d   = araddr_q;
        rready_d   = rready_q;

        case (state_q)
            IDLE, DONE, ERROR: begin
                if (start || (state_q == IDLE && auto_q)) begin
                    state_d    = WR_REQ;
                    step_d     = 2'd0;
                    poll_d     = '0;
                    done_d     = 1'b0;
                    error_d    = 1'b0;
                    err_code_d = 2'd0;
                    awvalid_d  = 1'b1;
                    wvalid_d   = 1'b1;
                    awaddr_d   = step_addr(2'd0);
                    wdata_d    = step_data(2'd0);
                    wstrb_d    = '1;
                end
            end
            WR_REQ: begin
                // Each channel retires on its own handshake; the later one moves on.
                if (m_axi_awready) awvalid_d = 1'b0;
                if (m_axi_wready)  wvalid_d  = 1'b0;
                if ((!awvalid_q || m_axi_awready) && (!wvalid_q || m_axi_wready)) begin
                    state_d  = WR_RESP;
                    bready_d = 1'b1;
                end
            end
            WR_RESP: begin
                if (m_axi_bvalid) begin
                    bready_d = 1'b0;
                    if (m_axi_bresp[1]) begin
                        state_d    = ERROR;
                        error_d    = 1'b1;
                        err_code_d = 2'd1;
                    end else if (step_q != 2'd2) begin
                        step_d    = step_q + 2'd1;
                        state_d   = WR_REQ;
                        awvalid_d = 1'b1;
                        wvalid_d  = 1'b1;
                        awaddr_d  = step_addr(step_q + 2'd1);
                        wdata_d   = step_data(step_q + 2'd1);
                    end else begin
                        state_d   = RD_REQ;
                        arvalid_d = 1'b1;
                        araddr_d  = STATUS_ADDR;
                    end
                end
            end
            RD_REQ: begin
                if (m_axi_arready) begin
                    arvalid_d = 1'b0;
                    rready_d  = 1'b1;
                    state_d   = RD_RESP;
                end
            end
            RD_RESP: begin
                if (m_axi_rvalid) begin
                    rready_d = 1'b0;
                    if (m_axi_rresp[1]) begin
                        state_d    = ERROR;
                        error_d    = 1'b1;
                        err_code_d = 2'd2;
                    end else if (m_axi_rdata[0]) begin
                        state_d = DONE;
                        done_d  = 1'b1;
                    end else begin
                        poll_d = poll_q + 1'b1;
                        if (poll_q == PW'(POLL_LIMIT - 1)) begin
                            state_d    = ERROR;
                            error_d    = 1'b1;
                            err_code_d = 2'd3;
                        end else begin
                            state_d   = RD_REQ;
                            arvalid_d = 1'b1;
                        end
                    end
                end
            end
            default: state_d = IDLE;
        endcase

        // A phase that makes no progress for TIMEOUT_CYCLES cycles aborts and withdraws everything.
        if (is_active(state_q) && state_d == state_q && timer_q == TW'(TIMEOUT_CYCLES - 1)) begin
            state_d    = ERROR;
            error_d    = 1'b1;
            err_code_d = 2'd3;
            awvalid_d  = 1'b0;
            wvalid_d   = 1'b0;
            bready_d   = 1'b0;
            arvalid_d  = 1'b0;
            rready_d   = 1'b0;
        end

        if (is_active(state_q) && state_d == state_q) timer_d = timer_q + 1'b1;
        busy_d = is_active(state_d);
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state_q    <= IDLE;
            step_q     <= 2'd0;
            poll_q     <= '0;
            timer_q    <= '0;
            armed_q    <= 1'b1;
            auto_q     <= 1'b0;
            busy_q     <= 1'b0;
            done_q     <= 1'b0;
            error_q    <= 1'b0;
            err_code_q <= 2'd0;
            awvalid_q  <= 1'b0;
            awaddr_q   <= '0;
            wvalid_q   <= 1'b0;
            wdata_q    <= '0;
            wstrb_q    <= '0;
            bready_q   <= 1'b0;
            arvalid_q  <= 1'b0;
            araddr_q   <= '0;
            rready_q   <= 1'b0;
        end else begin
            state_q    <= state_d;
            step_q     <= step_d;
            poll_q     <= poll_d;
            timer_q    <= timer_d;
            armed_q    <= armed_d;
            auto_q     <= auto_d;
            busy_q     <= busy_d;
            done_q     <= done_d;
            error_q    <= error_d;
            err_code_q <= err_code_d;
            awvalid_q  <= awvalid_d;
            awaddr_q   <= awaddr_d;
            wvalid_q   <= wvalid_d;
            wdata_q    <= wdata_d;
            wstrb_q    <= wstrb_d;
            bready_q   <= bready_d;
            arvalid_q  <= arvalid_d;
            araddr_q   <= araddr_d;
            rready_q   <= rready_d;
        end
    end

    assign busy          = busy_q;
    assign done          = done_q;
    assign error         = error_q;
    assign err_code      = err_code_q;
    assign m_axi_awaddr  = awaddr_q;
    assign m_axi_awprot  = 3'b000;
    assign m_axi_awvalid = awvalid_q;
    assign m_axi_wdata   = wdata_q;
    assign m_axi_wstrb   = wstrb_q;
    assign m_axi_wvalid  = wvalid_q;
    assign m_axi_bready  = bready_q;
    assign m_axi_araddr  = araddr_q;
    assign m_axi_arprot  = 3'b000;
    assign m_axi_arvalid = arvalid_q;
    assign m_axi_rready  = rready_q;

endmodule

// File: tb/tb_uart_cfg_master.sv
// Purpose: randomized bench for uart_cfg_master with a reactive AXI4-lite slave and a queue scoreboard.
// Latency: expectations are queued when a sequence is launched and popped as handshakes and completions appear.
// Backpressure: slave ready/valid delays are configurable per sequence, including a never-ready AR channel.
module tb_uart_cfg_master;
    localparam logic [31:0] BASE = 32'hFFFF_FFF8;
    localparam int TMO  = 8;
    localparam int PLIM = 16;

    logic        clk = 1'b0;
    logic        rst = 1'b1;
    logic        start = 1'b0;
    logic        busy, done, error;
    logic [1:0]  err_code;
    logic [31:0] m_axi_awaddr, m_axi_wdata, m_axi_araddr;
    logic [31:0] m_axi_rdata = '0;
    logic [2:0]  m_axi_awprot, m_axi_arprot;
    logic [3:0]  m_axi_wstrb;
    logic        m_axi_awvalid, m_axi_wvalid, m_axi_bready, m_axi_arvalid, m_axi_rready;
    logic        m_axi_awready = 1'b0, m_axi_wready = 1'b0, m_axi_bvalid = 1'b0;
    logic        m_axi_arready = 1'b0, m_axi_rvalid = 1'b0;
    logic [1:0]  m_axi_bresp = '0, m_axi_rresp = '0;

    always #5 clk = ~clk;

    uart_cfg_master #(
        .AXI_BASE_ADDR(BASE), .POLL_LIMIT(PLIM), .TIMEOUT_CYCLES(TMO)
    ) dut (
        .clk(clk), .rst(rst), .start(start), .busy(busy), .done(done), .error(error),
        .err_code(err_code),
        .m_axi_awaddr(m_axi_awaddr), .m_axi_awprot(m_axi_awprot), .m_axi_awvalid(m_axi_awvalid),
        .m_axi_awready(m_axi_awready),
        .m_axi_wdata(m_axi_wdata), .m_axi_wstrb(m_axi_wstrb), .m_axi_wvalid(m_axi_wvalid),
        .m_axi_wready(m_axi_wready),
        .m_axi_bresp(m_axi_bresp), .m_axi_bvalid(m_axi_bvalid), .m_axi_bready(m_axi_bready),
        .m_axi_araddr(m_axi_araddr), .m_axi_arprot(m_axi_arprot), .m_axi_arvalid(m_axi_arvalid),
        .m_axi_arready(m_axi_arready),
        .m_axi_rdata(m_axi_rdata), .m_axi_rresp(m_axi_rresp), .m_axi_rvalid(m_axi_rvalid),
        .m_axi_rready(m_axi_rready)
    );

    int nchk = 0;
    int nerr = 0;

    task automatic chk(input bit ok, input string name, input logic [63:0] act, input logic [63:0] exp);
        nchk++;
        if (!ok) begin
            nerr++;
            $display("FAIL %s: got 0x%0h, wanted 0x%0h (t=%0t)", name, act, exp, $time);
        end
    endtask

    // Scoreboard queues: addresses/data in issue order, and the final outcome {done, err_code}.
    logic [31:0] q_aw[$];
    logic [31:0] q_w[$];
    logic [31:0] q_ar[$];
    logic [2:0]  q_out[$];
    logic [2:0]  exp_out;

    // Slave configuration.
    int aw_dly, w_dly, b_dly, ar_dly, r_dly, werr_idx, rerr_idx, zero_reads;
    bit ar_never;
    int wr_idx, rd_idx;
    int ar_hs_cnt, arv_cycles;
    bit w_drop_seen;

    // Reference model: the register program and the outcome follow directly from the slave behaviour.
    task automatic push_expect();
        logic [31:0] a_ctrl, a_div, a_stat;
        logic [31:0] wa[3];
        logic [31:0] wd[3];
        int nw, nr, nsucc;
        a_ctrl = BASE + 32'h0;
        a_div  = BASE + 32'h4;
        a_stat = BASE + 32'h8;
        wa[0] = a_ctrl; wd[0] = 32'h3;
        wa[1] = a_div;  wd[1] = 32'd868;
        wa[2] = a_ctrl; wd[2] = 32'hC;
        nw = (werr_idx >= 0) ? werr_idx + 1 : 3;
        for (int i = 0; i < nw; i++) begin
            q_aw.push_back(wa[i]);
            q_w.push_back(wd[i]);
        end
        nr = 0;
        if (werr_idx >= 0) exp_out = 3'b001;
        else if (ar_never) exp_out = 3'b011;
        else begin
            nsucc = zero_reads + 1;
            if (nsucc <= PLIM) begin nr = nsucc; exp_out = 3'b100; end
            else begin nr = PLIM; exp_out = 3'b011; end
            if (rerr_idx >= 0 && rerr_idx < nr) begin nr = rerr_idx + 1; exp_out = 3'b010; end
        end
        for (int i = 0; i < nr; i++) q_ar.push_back(a_stat);
        q_out.push_back(exp_out);
    endtask

    task automatic set_cfg(input int awd, input int wd, input int bd, input int ard, input int rd,
                           input int werr, input int rerr, input int zr, input bit arn);
        aw_dly = awd; w_dly = wd; b_dly = bd; ar_dly = ard; r_dly = rd;
        werr_idx = werr; rerr_idx = rerr; zero_reads = zr; ar_never = arn;
        wr_idx = 0; rd_idx = 0; ar_hs_cnt = 0; arv_cycles = 0; w_drop_seen = 1'b0;
    endtask

    // Reactive slave: samples handshakes at negedge, drives its outputs 1 time unit after posedge.
    initial begin
        bit s_aw, s_w, s_b, s_ar, s_r, aw_got, w_got, wr_pend, rd_pend;
        int aw_cnt, w_cnt, b_cnt, ar_cnt, r_cnt;
        logic [31:0] rnd;
        aw_got = 0; w_got = 0; wr_pend = 0; rd_pend = 0;
        aw_cnt = 0; w_cnt = 0; b_cnt = 0; ar_cnt = 0; r_cnt = 0;
        forever begin
            @(negedge clk);
            s_aw = m_axi_awvalid && m_axi_awready;
            s_w  = m_axi_wvalid && m_axi_wready;
            s_b  = m_axi_bvalid && m_axi_bready;
            s_ar = m_axi_arvalid && m_axi_arready;
            s_r  = m_axi_rvalid && m_axi_rready;
            @(posedge clk);
            #1;
            if (rst) begin
                m_axi_awready = 0; m_axi_wready = 0; m_axi_bvalid = 0; m_axi_arready = 0; m_axi_rvalid = 0;
                aw_got = 0; w_got = 0; wr_pend = 0; rd_pend = 0; wr_idx = 0; rd_idx = 0;
                aw_cnt = 0; w_cnt = 0; b_cnt = 0; ar_cnt = 0; r_cnt = 0;
                continue;
            end
            if (s_aw) begin m_axi_awready = 0; aw_cnt = 0; aw_got = 1; end
            else if (m_axi_awvalid) begin
                if (aw_cnt >= aw_dly) m_axi_awready = 1; else aw_cnt++;
            end else begin m_axi_awready = 0; aw_cnt = 0; end
            if (s_w) begin m_axi_wready = 0; w_cnt = 0; w_got = 1; end
            else if (m_axi_wvalid) begin
                if (w_cnt >= w_dly) m_axi_wready = 1; else w_cnt++;
            end else begin m_axi_wready = 0; w_cnt = 0; end
            if (s_b) m_axi_bvalid = 0;
            if (aw_got && w_got) begin wr_pend = 1; aw_got = 0; w_got = 0; b_cnt = 0; end
            if (wr_pend && !m_axi_bvalid) begin
                if (b_cnt >= b_dly) begin
                    m_axi_bvalid = 1;
                    m_axi_bresp = (wr_idx == werr_idx) ? 2'b10 : 2'b00;
                    wr_idx++; wr_pend = 0;
                end else b_cnt++;
            end
            if (s_ar) begin m_axi_arready = 0; ar_cnt = 0; rd_pend = 1; r_cnt = 0; end
            else if (m_axi_arvalid && !ar_never) begin
                if (ar_cnt >= ar_dly) m_axi_arready = 1; else ar_cnt++;
            end else begin m_axi_arready = 0; ar_cnt = 0; end
            if (s_r) m_axi_rvalid = 0;
            if (rd_pend && !m_axi_rvalid) begin
                if (r_cnt >= r_dly) begin
                    rnd = $urandom();
                    m_axi_rvalid = 1;
                    m_axi_rdata = {rnd[31:1], (rd_idx >= zero_reads)};
                    m_axi_rresp = (rd_idx == rerr_idx) ? 2'b10 : 2'b00;
                    rd_idx++; rd_pend = 0;
                end else r_cnt++;
            end
        end
    end

    // Monitor: pops the scoreboard on every handshake and completion, and checks valid stability.
    logic        p_awv, p_awr, p_wv, p_wr, p_arv, p_arr, p_done, p_error;
    logic [31:0] p_awaddr, p_wdata, p_araddr, e;
    logic [2:0]  eo;
    initial begin
        p_awv = 0; p_awr = 0; p_wv = 0; p_wr = 0; p_arv = 0; p_arr = 0; p_done = 0; p_error = 0;
        p_awaddr = 0; p_wdata = 0; p_araddr = 0;
    end
    always @(negedge clk) begin
        if (rst) begin
            p_awv = 0; p_awr = 0; p_wv = 0; p_wr = 0; p_arv = 0; p_arr = 0; p_done = 0; p_error = 0;
        end else begin
            if (m_axi_awvalid && m_axi_awready) begin
                chk(q_aw.size() > 0, "unexpected_aw", m_axi_awaddr, 0);
                if (q_aw.size() > 0) begin
                    e = q_aw.pop_front();
                    chk({m_axi_awprot, m_axi_awaddr} == {3'b0, e}, "aw_addr", {m_axi_awprot, m_axi_awaddr}, e);
                end
            end
            if (m_axi_wvalid && m_axi_wready) begin
                chk(q_w.size() > 0, "unexpected_w", m_axi_wdata, 0);
                if (q_w.size() > 0) begin
                    e = q_w.pop_front();
                    chk({m_axi_wstrb, m_axi_wdata} == {4'hF, e}, "w_data", {m_axi_wstrb, m_axi_wdata}, {4'hF, e});
                end
            end
            if (m_axi_arvalid && m_axi_arready) begin
                ar_hs_cnt++;
                chk(q_ar.size() > 0, "unexpected_ar", m_axi_araddr, 0);
                if (q_ar.size() > 0) begin
                    e = q_ar.pop_front();
                    chk({m_axi_arprot, m_axi_araddr} == {3'b0, e}, "ar_addr", {m_axi_arprot, m_axi_araddr}, e);
                end
            end
            if (m_axi_arvalid) arv_cycles++;
            if (m_axi_awvalid && !m_axi_wvalid) w_drop_seen = 1'b1;
            if (p_awv && !p_awr && !error)
                chk(m_axi_awvalid && m_axi_awaddr == p_awaddr, "aw_hold", {m_axi_awvalid, m_axi_awaddr}, {1'b1, p_awaddr});
            if (p_wv && !p_wr && !error)
                chk(m_axi_wvalid && m_axi_wdata == p_wdata, "w_hold", {m_axi_wvalid, m_axi_wdata}, {1'b1, p_wdata});
            if (p_arv && !p_arr && !error)
                chk(m_axi_arvalid && m_axi_araddr == p_araddr, "ar_hold", {m_axi_arvalid, m_axi_araddr}, {1'b1, p_araddr});
            if (m_axi_bready)
                chk(!m_axi_awvalid && !m_axi_wvalid && !m_axi_arvalid, "bready_only_in_resp",
                    {m_axi_awvalid, m_axi_wvalid, m_axi_arvalid}, 0);
            if ((done && !p_done) || (error && !p_error)) begin
                chk(q_out.size() > 0, "unexpected_end", {done, error, err_code}, 0);
                if (q_out.size() > 0) begin
                    eo = q_out.pop_front();
                    chk(done == eo[2] && error == !eo[2] && err_code == eo[1:0] && !busy, "outcome",
                        {busy, done, error, err_code}, {1'b0, eo[2], !eo[2], eo[1:0]});
                end
            end
            p_awv = m_axi_awvalid; p_awr = m_axi_awready; p_awaddr = m_axi_awaddr;
            p_wv = m_axi_wvalid; p_wr = m_axi_wready; p_wdata = m_axi_wdata;
            p_arv = m_axi_arvalid; p_arr = m_axi_arready; p_araddr = m_axi_araddr;
            p_done = done; p_error = error;
        end
    end

    function automatic logic any_out();
        return |{busy, done, error, err_code, m_axi_awaddr, m_axi_awprot, m_axi_awvalid, m_axi_wdata,
                 m_axi_wstrb, m_axi_wvalid, m_axi_bready, m_axi_araddr, m_axi_arprot, m_axi_arvalid,
                 m_axi_rready};
    endfunction

    task automatic step();
        @(posedge clk);
        #2;
    endtask

    task automatic pulse_start();
        step();
        start = 1'b1;
        step();
        start = 1'b0;
    endtask

    task automatic wait_end();
        int n = 0;
        while (!(done || error) && n < 3000) begin step(); n++; end
        chk(n < 3000, "sequence_end_timeout", n, 3000);
    endtask

    task automatic finish_seq();
        repeat (3) step();
        chk(q_aw.size() + q_w.size() + q_ar.size() + q_out.size() == 0, "leftover_expectations",
            q_aw.size() + q_w.size() + q_ar.size() + q_out.size(), 0);
        chk({done, err_code} == exp_out && error == !exp_out[2] && !busy && !m_axi_arvalid && !m_axi_awvalid,
            "held_status", {busy, done, error, err_code}, {1'b0, exp_out[2], !exp_out[2], exp_out[1:0]});
    endtask

    task automatic run_started(input bit poke_busy);
        push_expect();
        pulse_start();
        chk(busy == 1'b1, "busy_after_start", busy, 1);
        if (poke_busy) pulse_start();
        wait_end();
        finish_seq();
    endtask

    initial begin
        #200000;
        $display("FAIL watchdog: simulation did not finish in time");
        $fatal(1, "watchdog");
    end

    initial begin
        int cnt;
        // Auto-start bring-up with an always-ready slave and STATUS ready at once.
        set_cfg(0, 0, 0, 0, 0, -1, -1, 0, 0);
        push_expect();
        repeat (3) step();
        chk(!any_out(), "reset_outputs", any_out(), 0);
        rst = 1'b0;
        step();
        chk(!busy && !m_axi_awvalid && !m_axi_wvalid, "auto_edge1", {busy, m_axi_awvalid, m_axi_wvalid}, 0);
        step();
        chk(busy && m_axi_awvalid && m_axi_wvalid, "auto_edge2", {busy, m_axi_awvalid, m_axi_wvalid}, 3'b111);
        cnt = 0;
        while (!done && cnt < 50) begin step(); cnt++; end
        chk(cnt == 8, "done_latency", cnt, 8);
        finish_seq();

        // awready 3 cycles after wready: wvalid retires alone while awvalid holds.
        set_cfg(3, 0, 0, 0, 0, -1, -1, 0, 0);
        run_started(1'b0);
        chk(w_drop_seen, "w_drops_alone", w_drop_seen, 1);

        // STATUS not ready for 5 reads.
        set_cfg(0, 0, 1, 0, 1, -1, -1, 5, 0);
        run_started(1'b0);
        chk(ar_hs_cnt == 6, "poll_6_reads", ar_hs_cnt, 6);

        // STATUS never ready: poll limit.
        set_cfg(0, 0, 0, 0, 0, -1, -1, 1000, 0);
        run_started(1'b0);
        chk(ar_hs_cnt == PLIM, "poll_limit_reads", ar_hs_cnt, PLIM);

        // SLVERR on the DIV write, then a clean rerun.
        set_cfg(0, 0, 0, 0, 0, 1, -1, 0, 0);
        run_started(1'b0);
        set_cfg(0, 0, 0, 0, 0, -1, -1, 0, 0);
        run_started(1'b1);

        // AR never accepted: timeout after TMO cycles in RD_REQ.
        set_cfg(0, 0, 0, 0, 0, -1, -1, 0, 1);
        run_started(1'b0);
        chk(arv_cycles == TMO, "ar_timeout_cycles", arv_cycles, TMO);

        // Asynchronous reset while waiting in WR_RESP, then auto restart.
        set_cfg(0, 0, 5, 0, 0, -1, -1, 0, 0);
        push_expect();
        pulse_start();
        cnt = 0;
        while (!m_axi_bready && cnt < 50) begin step(); cnt++; end
        chk(m_axi_bready == 1'b1, "reach_wr_resp", m_axi_bready, 1);
        #1 rst = 1'b1;
        #1;
        chk(!any_out(), "async_reset_outputs", any_out(), 0);
        q_aw.delete(); q_w.delete(); q_ar.delete(); q_out.delete();
        step();
        set_cfg(0, 0, 0, 0, 0, -1, -1, 2, 0);
        push_expect();
        step();
        rst = 1'b0;
        repeat (2) step();
        chk(busy == 1'b1, "restart_after_reset", busy, 1);
        wait_end();
        finish_seq();

        // Randomized sequences.
        for (int i = 0; i < 25; i++) begin
            int r, we, re;
            r  = $urandom_range(0, 7);
            we = (r < 3) ? r : -1;
            re = ($urandom_range(0, 5) == 0) ? int'($urandom_range(0, 4)) : -1;
            set_cfg($urandom_range(0, 3), $urandom_range(0, 3), $urandom_range(0, 3), $urandom_range(0, 3),
                    $urandom_range(0, 3), we, re, $urandom_range(0, 18), ($urandom_range(0, 9) == 0));
            run_started(we < 0 && (i % 3 == 0));
        end

        $display("Result: errors=%0d of %0d checks", nerr, nchk);
        $finish;
    end
endmodule
